gpio_filter_bank: RTL and testbench
===================================

# gpio_filter_bank

Multi-channel, parametrised GPIO input conditioner for the cartridge-bus and auxiliary pins. Each channel has a metastability synchroniser, a debouncer with a programmable run-length threshold, and registered edge and glitch strobes. It replaces per-pin two-sample filters with one bank. Every output is registered and holds its last stable value until a new level is confirmed.

## Interface
- CHANNELS, 8, number of independent input channels
- SYNC_STAGES, 2, synchroniser flops per channel (legal range ≥2)
- CNT_W, 4, run-counter width; maximum usable threshold is 2^CNT_W−1
- RESET_VAL, {CHANNELS{1'b1}}, per-channel reset/idle level (CHANNELS bits)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ena  in  1  sample strobe; debounce logic advances only on cycles with ena=1
- threshold  in  CNT_W  consecutive differing samples required to commit a new level; 0 is treated as 1
- din  in  CHANNELS  raw asynchronous pin inputs
- dout  out  CHANNELS  filtered, registered levels
- pos_edge  out  CHANNELS  one-clk pulse when dout commits 0→1
- neg_edge  out  CHANNELS  one-clk pulse when dout commits 1→0
- glitch  out  CHANNELS  one-clk pulse when a pending change is aborted
- any_edge  out  1  registered OR of the pos_edge|neg_edge terms, aligned with them

## Operation
- Synchroniser: a SYNC_STAGES-deep shift per channel, clocked every clk regardless of ena. Its last stage is sample s[i].
- Per-channel state: dout[i] and run counter cnt[i] (CNT_W bits).
- Effective threshold: T = (threshold==0) ? 1 : threshold.
- On a clk edge with ena=1, for each channel independently:
  - s==dout, cnt!=0: cnt←0, glitch pulse.
  - s==dout, cnt==0: no change.
  - s!=dout, cnt+1 ≥ T: dout←s, cnt←0, pos_edge or neg_edge pulse according to the new level.
  - s!=dout, cnt+1 < T: cnt←cnt+1.
- On a clk edge with ena=0: dout and cnt hold; pos_edge, neg_edge, glitch and any_edge are 0.
- All strobes are high for exactly one clk, on the same edge as the state update that produces them. pos_edge and neg_edge are never high together on one channel.
- Comparison width: cnt+1 is evaluated at CNT_W+1 bits, so there is no wrap. cnt never exceeds T−1.
- Threshold changed mid-run: the new T applies at the next ena sample. If cnt+1 ≥ new T and s!=dout, the change commits on that sample.
- Channels share ena and threshold and are otherwise fully independent. Simultaneous commits on several channels are all reported in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous release by the existing reset tree):
  - synchroniser stages = RESET_VAL
  - dout = RESET_VAL
  - cnt = 0
  - pos_edge = neg_edge = glitch = 0
  - any_edge = 0
- Reset asserted mid-run aborts any pending count. No strobe is emitted.
- Latency with ena held at 1: let k be the first edge that captures a new din level. s changes at edge k+SYNC_STAGES−1. dout and its edge strobe update at edge k+SYNC_STAGES+T−1.
- With ena gated, the commit occurs on the T-th ena=1 edge whose sample differs, with no intervening matching sample.
- any_edge has the same latency as the strobes (combinational OR of next-state terms, registered).
- dout is glitch-free: it is a direct flop output with no combinational path from din.

## Test plan
- Reset: hold reset_n=0 with din=8'h00 and RESET_VAL=8'hFF → dout=8'hFF, all strobes 0. Release and keep din=0, T=2 → dout=8'h00 at edge k+3, neg_edge=8'hFF for one cycle, any_edge=1 for one cycle.
- Clean edge, T=2, SYNC_STAGES=2, ena=1: ch0 driven 1→0 at edge k → dout[0] falls at k+3, neg_edge[0] high only during that cycle, other channels unchanged.
- Glitch reject, T=3: ch1 low for 2 clk then back high → dout[1] stays 1, glitch[1] pulses once, no neg_edge.
- ena gating, T=2: ena high every 4th clk and ch2 rises → dout[2] rises on the second ena edge after the synchroniser output changes. No strobes occur on ena=0 cycles.
- threshold=0 and threshold=15: ch3 toggles → with threshold=0, dout follows at k+2 (T=1). With threshold=15, dout follows after 15 consecutive differing ena samples, and a single matching sample at count 14 aborts with a glitch pulse.
- Concurrency and reset: ch4 rises and ch5 falls on the same edge → pos_edge[4] and neg_edge[5] in the same cycle. Asserting reset_n with cnt[6]=1 → cnt cleared, dout=RESET_VAL, no strobe.

Source files
------------

// File: rtl/gpio_filter_bank.sv
// Multi-channel GPIO input conditioner: per-channel synchroniser, run-length
// debouncer with programmable threshold, and registered edge/glitch strobes.
module gpio_filter_bank #(
  parameter int                  CHANNELS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  CNT_W       = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL   = {CHANNELS{1'b1}}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ena,
  input  logic [CNT_W-1:0]    threshold,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] pos_edge,
  output logic [CHANNELS-1:0] neg_edge,
  output logic [CHANNELS-1:0] glitch,
  output logic                any_edge
);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sample;
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CNT_W:0]      cnt_inc [CHANNELS];
  logic [CNT_W:0]      thr_eff;
  logic [CHANNELS-1:0] dout_d;
  logic [CHANNELS-1:0] pos_d;
  logic [CHANNELS-1:0] neg_d;
  logic [CHANNELS-1:0] glitch_d;
  logic                any_d;

  // The synchroniser runs every clock; only the debouncer honours ena.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sample  = sync_q[SYNC_STAGES-1];
  assign thr_eff = (threshold == '0) ? (CNT_W+1)'(1) : {1'b0, threshold};

  // One extra bit so the increment never wraps before the threshold compare.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) cnt_inc[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);
  end

  always_comb begin
    dout_d   = dout;
    pos_d    = '0;
    neg_d    = '0;
    glitch_d = '0;
    for (int i = 0; i < CHANNELS; i++) cnt_d[i] = cnt_q[i];
    if (ena) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sample[i] == dout[i]) begin
          if (cnt_q[i] != '0) begin
            cnt_d[i]    = '0;
            glitch_d[i] = 1'b1;
          end
        end else if (cnt_inc[i] >= thr_eff) begin
          dout_d[i] = sample[i];
          cnt_d[i]  = '0;
          pos_d[i]  = sample[i];
          neg_d[i]  = ~sample[i];
        end else begin
          cnt_d[i] = cnt_inc[i][CNT_W-1:0];
        end
      end
    end
    any_d = |(pos_d | neg_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout     <= RESET_VAL;
      pos_edge <= '0;
      neg_edge <= '0;
      glitch   <= '0;
      any_edge <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      dout     <= dout_d;
      pos_edge <= pos_d;
      neg_edge <= neg_d;
      glitch   <= glitch_d;
      any_edge <= any_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_gpio_filter_bank.sv
// Directed bench for gpio_filter_bank: per-cycle vector table plus hand-written
// sequences for long thresholds, concurrent commits and mid-run reset.
module tb_gpio_filter_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena;
  logic [3:0] threshold;
  logic [7:0] din;
  logic [7:0] dout, pos_edge, neg_edge, glitch;
  logic       any_edge;

  int total = 0;
  int bad   = 0;

  gpio_filter_bank #(
    .CHANNELS(8), .SYNC_STAGES(2), .CNT_W(4), .RESET_VAL(8'hFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .threshold(threshold), .din(din),
    .dout(dout), .pos_edge(pos_edge), .neg_edge(neg_edge), .glitch(glitch),
    .any_edge(any_edge)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ena;
    logic [3:0] thr;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic [7:0] e_pos;
    logic [7:0] e_neg;
    logic [7:0] e_glitch;
    logic       e_any;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic e, logic [3:0] t, logic [7:0] d,
                              logic [7:0] ed, logic [7:0] ep, logic [7:0] en,
                              logic [7:0] eg, logic ea);
    vec_t v;
    v.name = n; v.ena = e; v.thr = t; v.din = d;
    v.e_dout = ed; v.e_pos = ep; v.e_neg = en; v.e_glitch = eg; v.e_any = ea;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] t, input logic [7:0] d);
    ena = e;
    threshold = t;
    din = d;
  endtask

  task automatic cmp(input string n, input string f, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%02h want=%02h", n, f, act, exp);
    end
  endtask

  task automatic checkOutput(input string n, input logic [7:0] ed, input logic [7:0] ep,
                             input logic [7:0] en, input logic [7:0] eg, input logic ea);
    cmp(n, "dout", dout, ed);
    cmp(n, "pos_edge", pos_edge, ep);
    cmp(n, "neg_edge", neg_edge, en);
    cmp(n, "glitch", glitch, eg);
    cmp(n, "any_edge", {7'b0, any_edge}, {7'b0, ea});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // name, ena, thr, din, dout, pos, neg, glitch, any
    vecs.push_back(mk("rel1",  1, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rel2",  1, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rel3",  1, 2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("rel4",  1, 2, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1));
    vecs.push_back(mk("rel5",  1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("up1",   1, 2, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("up2",   1, 2, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("up3",   1, 2, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("up4",   1, 2, 8'h23, 8'h23, 8'h23, 8'h00, 8'h00, 1));
    vecs.push_back(mk("up5",   1, 2, 8'h23, 8'h23, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("fall1", 1, 2, 8'h22, 8'h23, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("fall2", 1, 2, 8'h22, 8'h23, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("fall3", 1, 2, 8'h22, 8'h23, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("fall4", 1, 2, 8'h22, 8'h22, 8'h00, 8'h01, 8'h00, 1));
    vecs.push_back(mk("fall5", 1, 2, 8'h22, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("gl1",   1, 3, 8'h20, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("gl2",   1, 3, 8'h20, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("gl3",   1, 3, 8'h22, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("gl4",   1, 3, 8'h22, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("gl5",   1, 3, 8'h22, 8'h22, 8'h00, 8'h00, 8'h02, 0));
    vecs.push_back(mk("gl6",   1, 3, 8'h22, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en1",   0, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en2",   0, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en3",   0, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en4",   1, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en5",   0, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en6",   0, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en7",   0, 2, 8'h26, 8'h22, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("en8",   1, 2, 8'h26, 8'h26, 8'h04, 8'h00, 8'h00, 1));
    vecs.push_back(mk("en9",   0, 2, 8'h26, 8'h26, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("t0_1",  1, 0, 8'h2E, 8'h26, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("t0_2",  1, 0, 8'h2E, 8'h26, 8'h00, 8'h00, 8'h00, 0));
    vecs.push_back(mk("t0_3",  1, 0, 8'h2E, 8'h2E, 8'h08, 8'h00, 8'h00, 1));
    vecs.push_back(mk("t0_4",  1, 0, 8'h2E, 8'h2E, 8'h00, 8'h00, 8'h00, 0));

    // Reset held with din low: outputs sit at the reset level.
    reset_n = 1'b0;
    applyStimulus(1, 2, 8'h00);
    repeat (3) tick();
    checkOutput("reset", 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ena, vecs[i].thr, vecs[i].din);
      tick();
      checkOutput(vecs[i].name, vecs[i].e_dout, vecs[i].e_pos, vecs[i].e_neg,
                  vecs[i].e_glitch, vecs[i].e_any);
    end

    // T=15 abort: 14 differing samples, then one matching sample.
    applyStimulus(0, 15, 8'h26);
    repeat (2) begin tick(); checkOutput("t15a_sync", 8'h2E, 0, 0, 0, 0); end
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 15, 8'h26);
      tick();
      checkOutput("t15a_run", 8'h2E, 0, 0, 0, 0);
    end
    applyStimulus(0, 15, 8'h2E);
    repeat (2) begin tick(); checkOutput("t15a_back", 8'h2E, 0, 0, 0, 0); end
    applyStimulus(1, 15, 8'h2E);
    tick();
    checkOutput("t15a_glitch", 8'h2E, 8'h00, 8'h00, 8'h08, 0);

    // T=15 commit on the 15th consecutive differing sample.
    applyStimulus(0, 15, 8'h26);
    repeat (2) begin tick(); checkOutput("t15c_sync", 8'h2E, 0, 0, 0, 0); end
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 15, 8'h26);
      tick();
      checkOutput("t15c_run", 8'h2E, 0, 0, 0, 0);
    end
    tick();
    checkOutput("t15c_commit", 8'h26, 8'h00, 8'h08, 8'h00, 1);
    tick();
    checkOutput("t15c_after", 8'h26, 0, 0, 0, 0);

    // ch4 rises and ch5 falls together.
    applyStimulus(1, 2, 8'h16);
    repeat (3) begin tick(); checkOutput("conc_wait", 8'h26, 0, 0, 0, 0); end
    tick();
    checkOutput("conc_commit", 8'h16, 8'h10, 8'h20, 8'h00, 1);

    // Reset while ch6 has a pending count of 1.
    applyStimulus(1, 2, 8'h56);
    repeat (3) begin tick(); checkOutput("rst_pend", 8'h16, 0, 0, 0, 0); end
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async", 8'hFF, 0, 0, 0, 0);
    tick();
    checkOutput("rst_hold", 8'hFF, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (3) begin tick(); checkOutput("rst_after", 8'hFF, 0, 0, 0, 0); end
    tick();
    checkOutput("rst_commit", 8'h56, 8'h00, 8'hA9, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
